// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined cordic between N requesters.
// A requester-ID tag shift pipeline, matched to the cordic latency, labels each returning result.
module cordic_arbiter #(
  parameter int N       = 4,
  parameter int LATENCY = 16,
  parameter int IDW     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [32*N-1:0]  req_theta,
  output logic [N-1:0]     req_ready,
  output logic [31:0]      cordic_theta,
  input  logic [31:0]      cordic_result,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic [31:0]      resp_result,
  output logic [IDW+5:0]   inflight,
  output logic             busy
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [31:0]     theta_q, theta_d;
  logic [LATENCY:0] tagValid_q;
  logic [IDW-1:0]  tagId_q [LATENCY+1];
  logic            respValid_q;
  logic [IDW-1:0]  respId_q;
  logic [31:0]     respResult_q;
  logic [IDW+5:0]  inflight_q, inflight_d;

  logic            grantAny;
  logic [IDW-1:0]  grantIdx;
  logic [31:0]     grantTheta;
  logic            accept;
  int              scanIdx;

  // Scan upward from the last winner so the previous grantee has lowest priority.
  always_comb begin
    grantAny   = 1'b0;
    grantIdx   = '0;
    grantTheta = '0;
    scanIdx    = 0;
    for (int off = 1; off <= N; off++) begin
      scanIdx = (int'(ptr_q) + off) % N;
      if (!grantAny && req_valid[scanIdx]) begin
        grantAny   = 1'b1;
        grantIdx   = IDW'(scanIdx);
        grantTheta = req_theta[scanIdx*32 +: 32];
      end
    end
  end

  assign accept = grantAny & ~reset;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grantIdx] = 1'b1;
  end

  always_comb begin
    theta_d    = accept ? grantTheta : theta_q;
    ptr_d      = accept ? grantIdx : ptr_q;
    inflight_d = inflight_q + {{(IDW+5){1'b0}}, accept}
                            - {{(IDW+5){1'b0}}, tagValid_q[LATENCY]};
  end

  // The response capture consumes the last tag stage, so a tag leaving the pipe retires its count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= IDW'(N-1);
      theta_q      <= '0;
      tagValid_q   <= '0;
      for (int s = 0; s <= LATENCY; s++) tagId_q[s] <= '0;
      respValid_q  <= 1'b0;
      respId_q     <= '0;
      respResult_q <= '0;
      inflight_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      theta_q      <= theta_d;
      tagValid_q   <= {tagValid_q[LATENCY-1:0], accept};
      tagId_q[0]   <= grantIdx;
      for (int s = 1; s <= LATENCY; s++) tagId_q[s] <= tagId_q[s-1];
      respValid_q  <= tagValid_q[LATENCY];
      respId_q     <= tagId_q[LATENCY];
      respResult_q <= cordic_result;
      inflight_q   <= inflight_d;
    end
  end

  assign cordic_theta = theta_q;
  assign resp_valid   = respValid_q;
  assign resp_id      = respId_q;
  assign resp_result  = respResult_q;
  assign inflight     = inflight_q;
  assign busy         = (inflight_q != '0);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: a stand-in cordic pipeline feeds results back,
// and a reference arbiter predicts grants, responses, inflight and the cordic operand.
module tb_cordic_arbiter;

  localparam int N       = 4;
  localparam int LATENCY = 16;
  localparam int IDW     = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    result;
    int             due;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [N-1:0]     reqValid;
  logic [32*N-1:0]  reqTheta;
  logic [N-1:0]     reqReady;
  logic [31:0]      cordicTheta;
  logic [31:0]      cordicResult;
  logic             respValid;
  logic [IDW-1:0]   respId;
  logic [31:0]      respResult;
  logic [IDW+5:0]   inflight;
  logic             busy;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int expInflight = 0;
  int expPtr = N-1;
  int maxInflight = 0;
  logic [31:0] expTheta = '0;
  exp_t sb[$];

  logic [31:0] cordPipe [LATENCY];

  cordic_arbiter #(.N(N), .LATENCY(LATENCY), .IDW(IDW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(reqValid),
    .req_theta(reqTheta),
    .req_ready(reqReady),
    .cordic_theta(cordicTheta),
    .cordic_result(cordicResult),
    .resp_valid(respValid),
    .resp_id(respId),
    .resp_result(respResult),
    .inflight(inflight),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in cordic: an arbitrary bijective transform delayed by LATENCY stages.
  function automatic logic [31:0] modelCordic(input logic [31:0] x);
    return ({x[7:0], x[31:8]} ^ 32'hA5C3_0F96) + 32'd1;
  endfunction

  initial for (int i = 0; i < LATENCY; i++) cordPipe[i] = '0;

  always @(posedge clk) begin
    cordPipe[0] <= cordicTheta;
    for (int i = 1; i < LATENCY; i++) cordPipe[i] <= cordPipe[i-1];
  end

  assign cordicResult = modelCordic(cordPipe[LATENCY-1]);

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [32*N-1:0] theta);
    @(posedge clk);
    #2;
    reqValid = valid;
    reqTheta = theta;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus('0, reqTheta);
  endtask

  // Sampled mid-cycle: inputs are stable here and will be what the next rising edge sees.
  always @(negedge clk) begin
    logic [N-1:0] expGrant;
    logic         found;
    int           gIdx;
    int           idx;
    exp_t         e;
    cyc++;
    if (reset) begin
      sb.delete();
      expInflight = 0;
      expTheta    = '0;
      expPtr      = N-1;
      checkOutput("rstReady", reqReady, 0);
      checkOutput("rstRespValid", respValid, 0);
      checkOutput("rstTheta", cordicTheta, 0);
      checkOutput("rstInflight", inflight, 0);
      checkOutput("rstBusy", busy, 0);
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        checkOutput("respValid", respValid, 1);
        checkOutput("respId", respId, e.id);
        checkOutput("respResult", respResult, e.result);
        expInflight--;
      end else begin
        checkOutput("respIdle", respValid, 0);
      end
      checkOutput("inflight", inflight, expInflight);
      checkOutput("busy", busy, (expInflight != 0));
      checkOutput("cordicTheta", cordicTheta, expTheta);
      if (int'(inflight) > maxInflight) maxInflight = int'(inflight);

      expGrant = '0;
      found    = 1'b0;
      gIdx     = 0;
      for (int off = 1; off <= N; off++) begin
        idx = (expPtr + off) % N;
        if (!found && reqValid[idx]) begin
          found = 1'b1;
          gIdx  = idx;
        end
      end
      if (found) expGrant[gIdx] = 1'b1;
      checkOutput("reqReady", reqReady, expGrant);
      if (found) begin
        e.id     = IDW'(gIdx);
        e.result = modelCordic(reqTheta[gIdx*32 +: 32]);
        e.due    = cyc + LATENCY + 2;
        sb.push_back(e);
        expInflight++;
        expTheta = reqTheta[gIdx*32 +: 32];
        expPtr   = gIdx;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    reqValid = '0;
    reqTheta = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // Single request from requester 1; other thetas must be ignored.
    applyStimulus(4'b0010, {32'h44444444, 32'h33333333, 32'hbf7f0000, 32'h11111111});
    idle(LATENCY + 4);

    // All requesters valid: rotation 0,1,2,3 with back-to-back returns.
    for (int i = 0; i < 24; i++)
      applyStimulus(4'b1111, {32'h00000000, 32'hbf800000, 32'h3f000000, 32'h3f800000});
    idle(LATENCY + 4);
    checkOutput("inflightSat", maxInflight, LATENCY + 1);

    // Fairness: requester 3 held, requester 1 joins at cycle 5.
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b1000, {32'h40490fdb, 32'h0, 32'h3e800000, 32'h0});
    for (int i = 0; i < 6; i++)
      applyStimulus(4'b1010, {32'h40490fdb, 32'h0, 32'h3e800000, 32'h0});
    idle(LATENCY + 4);

    // Idle gaps: accepts at relative cycles 0, 3 and 4.
    applyStimulus(4'b0100, {32'h0, 32'h3dcccccd, 32'h0, 32'h0});
    idle(2);
    applyStimulus(4'b0001, {32'h0, 32'h0, 32'h0, 32'h3f400000});
    applyStimulus(4'b1000, {32'hbf400000, 32'h0, 32'h0, 32'h0});
    idle(LATENCY + 4);

    // Withdrawal: requester 2 raised alongside requester 0 and dropped before winning.
    applyStimulus(4'b1000, {32'h3f100000, 32'h3f200000, 32'h0, 32'h3f300000});
    applyStimulus(4'b0101, {32'h3f100000, 32'h3f200000, 32'h0, 32'h3f300000});
    for (int i = 0; i < 3; i++)
      applyStimulus(4'b0001, {32'h3f100000, 32'h3f200000, 32'h0, 32'h3f300000});
    idle(LATENCY + 4);

    // Reset mid-flight after five accepts, asserted between clock edges.
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b0001, {96'h0, 32'h40000000 + 32'(i)});
    @(posedge clk);
    #3;
    reset    = 1'b1;
    reqValid = 4'b1111;
    #1;
    checkOutput("asyncReady", reqReady, 0);
    checkOutput("asyncTheta", cordicTheta, 0);
    checkOutput("asyncInflight", inflight, 0);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncRespValid", respValid, 0);
    repeat (2) @(posedge clk);
    #2;
    reset    = 1'b0;
    reqValid = '0;
    applyStimulus(4'b0001, {96'h0, 32'h3fc00000});
    idle(LATENCY + 6);

    checkOutput("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one fixed-latency, fully pipelined `cordic` unit (32-bit float theta in, 32-bit float result out, no handshake) between N requesters.
- Round-robin grant: at most one theta issued per cycle.
- A requester-ID tag travels in a shift pipeline matched to the cordic latency, so each result returns tagged with its originator.
- Sits between the function-evaluation front ends and the single `cordic` instance.

Parameters:
- N, 4, number of requesters (2..8).
- LATENCY, 16, edges from cordic_theta update until cordic_result reflects it (cordic_theta registered at edge k → cordic_result valid in the cycle after edge k+LATENCY).
- IDW, 2, width of requester ID (clog2(N)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N  request i holds a theta to evaluate.
- req_theta  in  32*N  theta of requester i at bits [32i+31:32i].
- req_ready  out  N  one-hot grant; request i is accepted at this edge when valid&ready.
- cordic_theta  out  32  registered operand to the cordic.
- cordic_result  in  32  cordic output.
- resp_valid  out  1  resp_result/resp_id valid this cycle (single-cycle pulse per result).
- resp_id  out  IDW  originating requester.
- resp_result  out  32  registered copy of cordic_result.
- inflight  out  IDW+6  number of accepted requests not yet returned.
- busy  out  1  inflight != 0.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - cordic_theta=0, resp_valid=0, resp_id=0, resp_result=0, inflight=0, busy=0.
  - All tag stages invalid; RR pointer=N-1, so requester 0 has first priority.
- Grant:
  - Combinational search from ptr+1 upward with wrap, over req_valid.
  - First asserted index g gets req_ready[g]=1; all other bits 0.
  - req_ready is 0 when no req_valid is set, and 0 while reset is asserted.
- Accept edge k (any grant):
  - cordic_theta <= req_theta[g]; ptr <= g.
  - Tag stage 0 <= {valid=1, id=g}.
  - With no grant: cordic_theta holds its value, ptr holds, stage 0 <= invalid.
- Tag pipeline:
  - LATENCY+1 stages, shifting every cycle unconditionally.
  - At edge k+LATENCY+1: resp_valid <= tag[LATENCY].valid, resp_id <= tag[LATENCY].id, resp_result <= cordic_result.
  - Latency from accept edge to resp_valid visible is therefore LATENCY+1 edges.
  - resp_valid is high for exactly one cycle per accepted request.
  - There is no response backpressure; requesters must always sink responses.
- Throughput:
  - One accept per cycle sustained.
  - A requester holding req_valid continuously with others idle is granted every cycle.
- Fairness:
  - With all N valid, grants rotate 0,1,..,N-1,0,…
  - A newly raised request waits at most N-1 cycles.
- inflight counter:
  - +1 on accept, -1 on a resp_valid capture; simultaneous accept and return leaves it unchanged.
  - Never exceeds LATENCY+1; never underflows.
  - busy = (inflight != 0).
- req_theta ordering: req_theta of a non-granted requester is ignored. Results return strictly in accept order.
- Reset mid-operation:
  - All tags are cleared and in-flight results are discarded (no resp_valid for them).
  - Garbage still draining from the cordic is never flagged valid.
- Requester deasserting req_valid: deasserting without being granted is legal; the request is simply withdrawn.

Test Plan:
- Single request: after reset, req_valid=4'b0010, theta=32'hbf7f0000 for one accepted cycle → req_ready=4'b0010 that cycle; cordic_theta=32'hbf7f0000 next cycle; resp_valid pulses exactly LATENCY+1 edges after accept with resp_id=1 and resp_result equal to the model cordic output; inflight 1→0.
- All requesters continuously valid, thetas 32'h3f800000, 32'h3f000000, 32'hbf800000, 32'h00000000 → grants cycle 0,1,2,3,0…; responses arrive back-to-back one per cycle in the same ID order with matching results; inflight saturates at LATENCY+1.
- Fairness: requester 3 held valid continuously, requester 1 raised at cycle 5 → requester 1 granted within one cycle of the next rotation, never starved; requester 3 regains grant the following cycle.
- Idle gaps: accepts at cycles 0, 3, 4 → resp_valid pulses at 0, 3, 4 (+LATENCY+1) only; resp_valid low between; cordic_theta holds its value during idle cycles.
- Reset mid-flight: 5 requests accepted, reset asserted asynchronously between clock edges before any return → all outputs at reset values immediately; no resp_valid ever appears for those 5; after release, a new request to ID 0 completes normally.
- Withdrawal: req_valid[2] raised then dropped while requester 0 is granted → requester 2 is never granted; no response with resp_id=2.
